// File: rtl/gate_row_sequencer.sv
// gate_row_sequencer: initiator side of the r/z gate interface.
// A start snapshots xt/ht1, issues CELLNUM gate rows (Wx row, Wh row, bias
// element) one per cycle, collects CELLNUM in-order scalar results and packs
// them into gate_vec. Optional build macro GATE_TIMEOUT_EN adds a WAIT-state
// idle watchdog that aborts the sequence after TIMEOUT quiet cycles.
module gate_row_sequencer #(
  parameter int INPUTDIMEN = 4,
  parameter int CELLNUM    = 4,
  parameter int DATABIT    = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [INPUTDIMEN*DATABIT-1:0]           xt,
  input  logic [CELLNUM*DATABIT-1:0]              ht1,
  input  logic [CELLNUM*INPUTDIMEN*DATABIT-1:0]   wx,
  input  logic [CELLNUM*CELLNUM*DATABIT-1:0]      wh,
  input  logic [CELLNUM*DATABIT-1:0]              bias,
  output logic                                    g_en,
  output logic [INPUTDIMEN*DATABIT-1:0]           g_xt,
  output logic [CELLNUM*DATABIT-1:0]              g_ht1,
  output logic [INPUTDIMEN*DATABIT-1:0]           g_wx_row,
  output logic [CELLNUM*DATABIT-1:0]              g_wh_row,
  output logic signed [DATABIT-1:0]               g_b,
  input  logic                                    g_result_valid,
  input  logic signed [DATABIT-1:0]               g_result,
  output logic                                    busy,
  output logic                                    done,
  output logic [CELLNUM*DATABIT-1:0]              gate_vec,
  output logic                                    err,
  output logic                                    timeout
);

  localparam int CW = $clog2(CELLNUM + 1);
  localparam int XW = INPUTDIMEN * DATABIT;
  localparam int HW = CELLNUM * DATABIT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CW-1:0]             r_issue_cnt;
  logic [CW-1:0]             r_rcv_cnt;
  logic [CW-1:0]             w_rcv_nxt;
  logic                      w_collect;
  logic                      w_accept;
  logic                      w_unexp;
  logic                      w_start_acc;
  logic                      w_timeout;
  logic [XW-1:0]             r_xt;
  logic [HW-1:0]             r_ht1;
  logic [XW-1:0]             r_wx_row;
  logic [HW-1:0]             r_wh_row;
  logic signed [DATABIT-1:0] r_b;
  logic [XW-1:0]             w_wx_row;
  logic [HW-1:0]             w_wh_row;
  logic signed [DATABIT-1:0] w_b;
  logic [HW-1:0]             r_gate_vec;
  logic                      r_err;

  // Result acceptance: only while collecting and a free slot remains.
  always_comb begin
    w_collect = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                (r_rcv_cnt != CW'(CELLNUM));
    w_accept  = g_result_valid && w_collect;
    w_unexp   = g_result_valid && !w_collect;
    w_rcv_nxt = r_rcv_cnt + CW'(w_accept);
  end

`ifdef GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;

  // Idle watchdog: counts quiet WAIT cycles, restarts on every result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != S_WAIT) || g_result_valid) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !g_result_valid &&
                     (r_idle_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    g_en        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        g_en = 1'b1;
        busy = 1'b1;
        if (r_issue_cnt == CW'(CELLNUM - 1)) begin
          w_state_nxt = (w_rcv_nxt == CW'(CELLNUM)) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_rcv_nxt == CW'(CELLNUM)) begin
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row select: live mux while issuing, otherwise replay the last issued row.
  always_comb begin
    w_wx_row = r_wx_row;
    w_wh_row = r_wh_row;
    w_b      = r_b;
    if (r_state == S_ISSUE) begin
      for (int k = 0; k < CELLNUM; k++) begin
        if (r_issue_cnt == CW'(k)) begin
          w_wx_row = wx[k*XW +: XW];
          w_wh_row = wh[k*HW +: HW];
          w_b      = bias[k*DATABIT +: DATABIT];
        end
      end
    end
  end

  // Hold registers so row outputs keep their last value outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wx_row <= '0;
      r_wh_row <= '0;
      r_b      <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wx_row <= w_wx_row;
      r_wh_row <= w_wh_row;
      r_b      <= w_b;
    end
  end

  // Snapshots, counters and result packing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xt        <= '0;
      r_ht1       <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
      r_gate_vec  <= '0;
    end else if (w_start_acc) begin
      r_xt        <= xt;
      r_ht1       <= ht1;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
      r_gate_vec  <= '0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_accept) begin
        r_rcv_cnt <= w_rcv_nxt;
        for (int k = 0; k < CELLNUM; k++) begin
          if (r_rcv_cnt == CW'(k)) begin
            r_gate_vec[k*DATABIT +: DATABIT] <= g_result;
          end
        end
      end
    end
  end

  // Sticky error: an unexpected strobe wins over the clear from a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_unexp) begin
      r_err <= 1'b1;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end
  end

  assign g_xt     = r_xt;
  assign g_ht1    = r_ht1;
  assign g_wx_row = w_wx_row;
  assign g_wh_row = w_wh_row;
  assign g_b      = w_b;
  assign gate_vec = r_gate_vec;
  assign err      = r_err;
  assign timeout  = w_timeout;

endmodule

// File: tb/tb_gate_row_sequencer.sv
// Bench for gate_row_sequencer: in-bench pipelined gate model, table vectors,
// hand-written corner sequences and randomized transactions.
module tb_gate_row_sequencer;
  localparam int INPUTDIMEN = 4;
  localparam int CELLNUM    = 4;
  localparam int DATABIT    = 16;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [63:0]         xt;
  logic [63:0]         ht1;
  logic [255:0]        wx;
  logic [255:0]        wh;
  logic [63:0]         bias;
  logic                g_en;
  logic [63:0]         g_xt;
  logic [63:0]         g_ht1;
  logic [63:0]         g_wx_row;
  logic [63:0]         g_wh_row;
  logic signed [15:0]  g_b;
  logic                g_result_valid;
  logic signed [15:0]  g_result;
  logic                busy;
  logic                done;
  logic [63:0]         gate_vec;
  logic                err;
  logic                timeout;

  gate_row_sequencer #(
    .INPUTDIMEN(INPUTDIMEN), .CELLNUM(CELLNUM), .DATABIT(DATABIT), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .xt(xt), .ht1(ht1), .wx(wx),
    .wh(wh), .bias(bias), .g_en(g_en), .g_xt(g_xt), .g_ht1(g_ht1),
    .g_wx_row(g_wx_row), .g_wh_row(g_wh_row), .g_b(g_b),
    .g_result_valid(g_result_valid), .g_result(g_result), .busy(busy),
    .done(done), .gate_vec(gate_vec), .err(err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [15:0] v;
  } res_t;

  typedef struct {
    int          lat;
    logic [63:0] bias;
    logic [15:0] off;
    logic [63:0] exp_vec;
    int          exp_rel;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [15:0] off = '0;
  int          m_idx = 0;
  int          drop_from = CELLNUM;
  int          en_cnt, done_cnt, to_cnt, done_cyc, to_cyc;
  logic [15:0] gb_log[$];
  logic [63:0] wx_log[$];
  logic [63:0] wh_log[$];
  res_t        pend[$];
  vec_t        tbl[4];
  int          s, lt, xr;
  bit          seen, sd;
  logic [63:0] gv, ev;

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs 1 unit after the edge, run the gate model.
  task automatic step();
    res_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (g_en) begin
      en_cnt++;
      gb_log.push_back(g_b);
      wx_log.push_back(g_wx_row);
      wh_log.push_back(g_wh_row);
      if (m_idx < drop_from) begin
        r.t = cyc + lat;
        r.v = g_b + off;
        pend.push_back(r);
      end
      m_idx++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    g_result_valid = 1'b0;
    g_result       = '0;
    if (pend.size() > 0 && pend[0].t == cyc) begin
      g_result_valid = 1'b1;
      g_result       = pend[0].v;
      void'(pend.pop_front());
    end
  endtask

  task automatic run_txn(input string tag, input int lat_i, input logic [15:0] off_i,
                         input int extra_rel, input bit sid,
                         input logic [63:0] exp_vec, input int exp_rel);
    int           s0, d_rel;
    bit           got;
    logic [63:0]  exp_xt, exp_ht1, gbp;
    logic [255:0] wxp, whp;
    xt = rnd64(); ht1 = rnd64(); wx = rnd256(); wh = rnd256();
    exp_xt = xt; exp_ht1 = ht1;
    lat = lat_i; off = off_i; m_idx = 0; drop_from = CELLNUM;
    en_cnt = 0; done_cnt = 0; to_cnt = 0;
    gb_log.delete(); wx_log.delete(); wh_log.delete();
    s0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("%s_busy_rise", tag), busy, 1'b1);
    chk($sformatf("%s_err_clr", tag), err, 1'b0);
    xt = ~xt; ht1 = ~ht1;
    chk($sformatf("%s_snap_xt", tag), g_xt, exp_xt);
    chk($sformatf("%s_snap_ht1", tag), g_ht1, exp_ht1);
    got = 1'b0; d_rel = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (cyc - s0 == extra_rel) start = 1'b1;
      step();
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        d_rel = cyc - s0;
        if (sid) start = 1'b1;
      end
    end
    chk($sformatf("%s_done_seen", tag), got, 1'b1);
    step();
    start = 1'b0;
    chk($sformatf("%s_idle1", tag), busy, 1'b0);
    step();
    chk($sformatf("%s_idle2", tag), busy, 1'b0);
    gbp = '0; wxp = '0; whp = '0;
    for (int k = 0; k < CELLNUM && k < gb_log.size(); k++) begin
      gbp[k*16 +: 16] = gb_log[k];
      wxp[k*64 +: 64] = wx_log[k];
      whp[k*64 +: 64] = wh_log[k];
    end
    chk($sformatf("%s_done_rel", tag), d_rel, exp_rel);
    chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s_en_cnt", tag), en_cnt, CELLNUM);
    chk($sformatf("%s_gb_seq", tag), gbp, bias);
    chk($sformatf("%s_wx_seq", tag), wxp, wx);
    chk($sformatf("%s_wh_seq", tag), whp, wh);
    chk($sformatf("%s_gvec", tag), gate_vec, exp_vec);
    chk($sformatf("%s_err", tag), err, 1'b0);
    chk($sformatf("%s_to_cnt", tag), to_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{6, 64'h0004_0003_0002_0001, 16'h0100, 64'h0104_0103_0102_0101, 11};
    tbl[1] = '{1, 64'h0004_0003_0002_0001, 16'h0100, 64'h0104_0103_0102_0101, 6};
    tbl[2] = '{3, 64'h8000_7FFF_FFFF_0000, 16'h0100, 64'h8100_80FF_00FF_0100, 8};
    tbl[3] = '{2, 64'h1234_5678_9ABC_DEF0, 16'h0000, 64'h1234_5678_9ABC_DEF0, 7};

    rst_n = 1'b0; start = 1'b0; g_result_valid = 1'b0; g_result = '0;
    xt = rnd64(); ht1 = rnd64(); wx = rnd256(); wh = rnd256(); bias = rnd64();
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_gen", g_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_gvec", gate_vec, 64'h0);
    chk("rst_gxt", g_xt, 64'h0);
    chk("rst_ght1", g_ht1, 64'h0);
    chk("rst_wxrow", g_wx_row, 64'h0);
    chk("rst_whrow", g_wh_row, 64'h0);
    chk("rst_gb", 16'(g_b), 16'h0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      bias = tbl[v].bias;
      run_txn($sformatf("vec%0d", v), tbl[v].lat, tbl[v].off, -1, 1'b0,
              tbl[v].exp_vec, tbl[v].exp_rel);
    end

    // start during ISSUE and in the done cycle are both ignored
    bias = 64'h0004_0003_0002_0001;
    run_txn("busy_start", 6, 16'h0100, 2, 1'b1, 64'h0104_0103_0102_0101, 11);
    run_txn("after_busy", 2, 16'h0100, -1, 1'b0, 64'h0104_0103_0102_0101, 7);

    // unexpected result in IDLE
    gv = gate_vec;
    g_result_valid = 1'b1;
    g_result = 16'h7FFF;
    step();
    step();
    chk("idle_inj_err", err, 1'b1);
    chk("idle_inj_gvec", gate_vec, gv);
    bias = 64'h0010_0020_0030_0040;
    run_txn("after_inj", 4, 16'h0001, -1, 1'b0, 64'h0011_0021_0031_0041, 9);

    // asynchronous reset in the middle of WAIT
    bias = 64'h0004_0003_0002_0001; wx = rnd256(); wh = rnd256();
    lat = 3; off = 16'h0100; m_idx = 0; drop_from = CELLNUM;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("rstw_pre_busy", busy, 1'b1);
    chk("rstw_pre_gen", g_en, 1'b0);
    chk("rstw_pre_gvec", gate_vec, 64'h0000_0000_0102_0101);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_done", done, 1'b0);
    chk("rstw_gvec", gate_vec, 64'h0);
    chk("rstw_gen", g_en, 1'b0);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("rstw_late_err", err, 1'b1);
    chk("rstw_late_gvec", gate_vec, 64'h0);
    chk("rstw_late_busy", busy, 1'b0);
    bias = 64'h0004_0003_0002_0001;
    run_txn("after_rst", 1, 16'h0100, -1, 1'b0, 64'h0104_0103_0102_0101, 6);

`ifdef GATE_TIMEOUT_EN
    // model drops the 3rd result onward: watchdog expires 32 cycles after the 2nd
    bias = 64'h0004_0003_0002_0001;
    lat = 6; off = 16'h0100; m_idx = 0; drop_from = 2; to_cnt = 0; done_cnt = 0;
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (timeout) seen = 1'b1;
    end
    chk("to_seen", seen, 1'b1);
    chk("to_rel", to_cyc - s, 40);
    step();
    chk("to_pulse_cnt", to_cnt, 1);
    chk("to_done_cnt", done_cnt, 0);
    chk("to_busy", busy, 1'b0);
    chk("to_gvec", gate_vec, 64'h0000_0000_0102_0101);
    chk("to_err", err, 1'b0);
    drop_from = CELLNUM;
`endif

    // randomized transactions against the arithmetic reference
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 3) == 0) begin
        gv = gate_vec;
        g_result_valid = 1'b1;
        g_result = 16'($urandom());
        step();
        step();
        chk($sformatf("rnd%0d_spur_err", n), err, 1'b1);
        chk($sformatf("rnd%0d_spur_gvec", n), gate_vec, gv);
      end
      lt   = int'($urandom_range(1, 10));
      bias = rnd64();
      off  = 16'($urandom());
      xr   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CELLNUM + lt)) : -1;
      sd   = 1'($urandom_range(0, 1));
      for (int k = 0; k < CELLNUM; k++) ev[k*16 +: 16] = bias[k*16 +: 16] + off;
      run_txn($sformatf("rnd%0d", n), lt, off, xr, sd, ev, CELLNUM + lt + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_row_sequencer.md
Name: gate_row_sequencer

Overview:
Initiator side of the r/z gate interface. On a start pulse it snapshots xt and ht1, then issues one gate row per cycle (weight rows from Wx and Wh plus the bias element) to a pipelined gate unit. It collects the CELLNUM scalar results returned on the result_valid/result interface and packs them into one gate vector (r_t or z_t) for the hidden-layer update.

Parameters:
INPUTDIMEN, 4, elements in xt and in each Wx row
CELLNUM, 4, cells = rows issued = results collected
DATABIT, 16, signed fixed-point element width
TIMEOUT, 32, max idle cycles in WAIT between results (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request one gate-vector computation; accepted only in IDLE
xt  in  INPUTDIMEN*DATABIT  input vector, element j at [j*DATABIT +: DATABIT]
ht1  in  CELLNUM*DATABIT  previous hidden state
wx  in  CELLNUM*INPUTDIMEN*DATABIT  Wx matrix, row k at [k*INPUTDIMEN*DATABIT +: INPUTDIMEN*DATABIT]
wh  in  CELLNUM*CELLNUM*DATABIT  Wh matrix, row k at [k*CELLNUM*DATABIT +: CELLNUM*DATABIT]
bias  in  CELLNUM*DATABIT  bias vector, element k at [k*DATABIT +: DATABIT]
g_en  out  1  row-issue strobe to the gate unit
g_xt  out  INPUTDIMEN*DATABIT  snapshot of xt
g_ht1  out  CELLNUM*DATABIT  snapshot of ht1
g_wx_row  out  INPUTDIMEN*DATABIT  Wx row being issued
g_wh_row  out  CELLNUM*DATABIT  Wh row being issued
g_b  out  DATABIT  signed bias element being issued
g_result_valid  in  1  gate result strobe
g_result  in  DATABIT  signed gate result
busy  out  1  high from the start-acceptance cycle through DONE
done  out  1  one-cycle pulse; gate_vec complete
gate_vec  out  CELLNUM*DATABIT  packed results, element k at [k*DATABIT +: DATABIT]
err  out  1  sticky: unexpected result_valid; cleared by reset or an accepted start
timeout  out  1  one-cycle pulse; present only with the optional feature, tied 0 otherwise

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0, counters 0, gate_vec 0, snapshots 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on start=1, latch xt->g_xt and ht1->g_ht1, clear issue_cnt, rcv_cnt and err, clear gate_vec to 0, then go to ISSUE. busy rises in the next cycle.
- ISSUE: g_en=1 for exactly CELLNUM consecutive cycles. In cycle k, g_wx_row, g_wh_row and g_b carry row/element k, selected combinationally from issue_cnt. wx, wh and bias must stay stable while busy; they are not latched. After issuing row CELLNUM-1, go to WAIT, or to DONE if all results have already arrived.
- Collection runs in ISSUE and WAIT. Each g_result_valid writes g_result into slot rcv_cnt, then increments rcv_cnt. The gate unit returns results in order, with fixed latency >= 1. Results may arrive while later rows are still issuing.
- WAIT: when rcv_cnt reaches CELLNUM, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. gate_vec holds its value until the next accepted start.
- Outside ISSUE/WAIT, g_en=0 and the row outputs hold their last value.
- Unexpected result: g_result_valid in IDLE or DONE, or while rcv_cnt==CELLNUM, sets err. The data is discarded and no slot changes.
- start while busy: ignored, with no effect on the sequence in flight.
- start in the same cycle as done: ignored; start is accepted one cycle later in IDLE.
- Arithmetic: no arithmetic on data. Counters are $clog2(CELLNUM+1) bits wide.

Optional Feature:
GATE_TIMEOUT_EN.
- Defined: an idle counter runs in WAIT and resets on every g_result_valid. If it reaches TIMEOUT, the block pulses timeout for one cycle and returns to IDLE without done. Slots already filled are kept and unfilled slots stay 0. err is unaffected.
- Undefined: WAIT waits indefinitely and the timeout port is tied to 0.

Test Plan:
- Bench gate model: 6-cycle latency, result = g_b + 0x0100. Set bias = {0x0004,0x0003,0x0002,0x0001} and pulse start. Required: g_en high 4 cycles with g_b = 1,2,3,4; done 1 cycle after the 4th result; gate_vec = {0x0104,0x0103,0x0102,0x0101}; err=0.
- Model latency 1: results overlap issue. Required: done in the cycle after ISSUE ends plus 1; gate_vec correct.
- Pulse start again during ISSUE, and again in the done cycle. Required: neither is accepted; exactly one done; a later start in IDLE runs normally.
- Inject g_result_valid with 0x7FFF in IDLE. Required: err=1, gate_vec unchanged. The next start clears err.
- Assert rst_n=0 mid-WAIT. Required: immediate busy=0, done=0, gate_vec=0, g_en=0. Late results after reset set err.
- With GATE_TIMEOUT_EN and TIMEOUT=32, the model drops the 3rd result. Required: timeout pulses 32 cycles after the 2nd result; no done; slots 0,1 filled, slots 2,3 = 0.
